mdu_ex: RTL and testbench

- Multiply/divide unit for the EX stage.
- Consumes the operands and control latched by the ID→EX pipeline register, and executes multi-cycle MULT/MULTU/DIV/DIVU into architectural HI/LO.
- Returns a stall request to the ID-stage hazard logic, which turns it into a bubble (`clear`) on the ID→EX register.
- Honours the exception flush (`clearAll`) so a cancelled instruction never commits to HI/LO.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_arith.sv | 80 ++++++++
 rtl/mdu_ex.sv | 116 +++++++++++
 tb/tb_mdu_ex.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2
  } state_t;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W          = 4;

  // Ops that occupy the unit for several cycles and therefore stall ID.
  function automatic logic is_md_op(input op_t o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: product, quotient/remainder and the
// divide-by-zero passthrough that keeps HI/LO unchanged.
module mdu_arith
  import mdu_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] b_safe_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] b_safe_u;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;

  assign a_s      = $signed(rs_val);
  assign b_s      = $signed(rt_val);
  assign div_zero = (rt_val == 32'h0);
  // Most-negative / -1 cannot be represented; pin its result explicitly.
  assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{a_s[31]}}, a_s}) * $signed({{32{b_s[31]}}, b_s});
  assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};

  // Divisor forced to 1 in the special cases so the dividers never see 0 or overflow.
  assign b_safe_s = (div_zero || div_ovf) ? 32'sd1 : b_s;
  assign b_safe_u = div_zero ? 32'd1 : rt_val;
  assign quo_s    = a_s / b_safe_s;
  assign rem_s    = a_s % b_safe_s;
  assign quo_u    = rs_val / b_safe_u;
  assign rem_u    = rs_val % b_safe_u;

  // Select the {hi, lo} result for the requested operation.
  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    unique case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (div_ovf) begin
          res_hi = 32'h0;
          res_lo = 32'h8000_0000;
        end else if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin
        res_hi = cur_hi;
        res_lo = cur_lo;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: accepts an op from ID/EX, holds the result
// in shadow registers for a fixed busy period, then commits it to HI/LO.
module mdu_ex
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  op_t         op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        clearAll,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [31:0]        hi_n;
  logic [31:0]        lo_n;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               accept;
  logic               load_shadow;
  logic               commit;

  mdu_arith u_arith (
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cur_hi (hi),
    .cur_lo (lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // A flushed or stray start is never accepted.
  assign accept   = start && !clearAll && (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign md_stall = busy || (start && is_md_op(op));

  // State and busy counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: load the counter on acceptance, commit when it hits zero.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    load_shadow = 1'b0;
    commit      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept && (op == OP_MULT || op == OP_MULTU)) begin
          state_nx    = ST_MUL_BUSY;
          cnt_nx      = CNT_W'(MUL_CYCLES - 1);
          load_shadow = 1'b1;
        end else if (accept && (op == OP_DIV || op == OP_DIVU)) begin
          state_nx    = ST_DIV_BUSY;
          cnt_nx      = CNT_W'(DIV_CYCLES - 1);
          load_shadow = 1'b1;
        end
      end
      ST_MUL_BUSY, ST_DIV_BUSY: begin
        if (cnt == '0) begin
          state_nx = ST_IDLE;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Shadow and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_n <= '0;
      lo_n <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (load_shadow) begin
        hi_n <= res_hi;
        lo_n <= res_lo;
      end
      if (commit) begin
        hi <= hi_n;
        lo <= lo_n;
      end else if (accept && op == OP_MTHI) begin
        hi <= rs_val;
      end else if (accept && op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ex.sv
// Bench for mdu_ex: directed vector table, hand-written corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_mdu_ex;
  import mdu_pkg::*;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  op_t         op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        clearAll;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;
  logic [31:0] mh;
  logic [31:0] ml;

  typedef struct {
    op_t         o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  mdu_ex #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .clearAll (clearAll),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics computed in 64-bit arithmetic.
  task automatic ref_op(input op_t o, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] h, inout logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      OP_MULT:  begin q = sa * sb; h = q[63:32]; l = q[31:0]; end
      OP_MULTU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      OP_DIVU:  if (b != 0) begin uq = ua / ub; ur = ua % ub; l = uq[31:0]; h = ur[31:0]; end
      OP_MTHI:  h = a;
      OP_MTLO:  l = a;
      default:  ;
    endcase
  endtask

  // Present an op for one cycle (called just after a rising edge).
  task automatic issue(input op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic clr, input logic exp_stall, input string nm);
    op = o; rs_val = a; rt_val = b; clearAll = clr; start = 1'b1;
    #1;
    check({nm, " md_stall"}, {31'h0, md_stall}, {31'h0, exp_stall});
    @(posedge clk); #1;
    start = 1'b0; clearAll = 1'b0; op = OP_NONE;
  endtask

  // Count edges until busy drops; optionally inject clearAll (kind 1) or a
  // stray MTHI start (kind 2) during busy cycle number inj.
  task automatic wait_idle(input int inj, input int kind, output int n);
    n = 0;
    while (busy && n < 100) begin
      if (n + 1 == inj && kind == 1) clearAll = 1'b1;
      if (n + 1 == inj && kind == 2) begin
        start = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD;
      end
      @(posedge clk); #1;
      clearAll = 1'b0; start = 1'b0; op = OP_NONE;
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL busy timeout: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  initial begin
    int n;
    tests = 0; fails = 0;
    start = 1'b0; op = OP_NONE; rs_val = '0; rt_val = '0; clearAll = 1'b0;
    reset = 1'b1;

    vecs[0]  = '{OP_MTHI,  32'h0000_0011, 32'h0,          32'h0000_0011, 32'h0000_0000, 0};
    vecs[1]  = '{OP_MTLO,  32'h0000_0022, 32'h0,          32'h0000_0011, 32'h0000_0022, 0};
    vecs[2]  = '{OP_DIVU,  32'h0000_0007, 32'h0,          32'h0000_0011, 32'h0000_0022, DIVC};
    vecs[3]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, MULC};
    vecs[4]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,          32'h0000_0001, 32'hFFFF_FFFE, MULC};
    vecs[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC};
    vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, DIVC};
    vecs[7]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'hA,          32'h0000_0005, 32'h1999_9999, DIVC};
    vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, DIVC};
    vecs[9]  = '{OP_MTLO,  32'h0000_ABCD, 32'h0,          32'h0000_0001, 32'h0000_ABCD, 0};
    vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, MULC};

    // Asynchronous reset, asserted mid-cycle.
    #2 reset = 1'b0;
    #1;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset md_stall", {31'h0, md_stall}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post-reset hi", hi, 32'h0);
    mh = '0; ml = '0;

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b, 1'b0, vecs[i].cyc != 0, $sformatf("vec%0d", i));
      wait_idle(0, 0, n);
      check($sformatf("vec%0d cycles", i), n, vecs[i].cyc);
      check($sformatf("vec%0d hi", i), hi, vecs[i].eh);
      check($sformatf("vec%0d lo", i), lo, vecs[i].el);
      mh = vecs[i].eh; ml = vecs[i].el;
    end

    // Flushed in the acceptance cycle: nothing starts, nothing written.
    issue(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b1, "flush-accept");
    check("flush-accept busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    check("flush-accept hi", hi, mh);
    check("flush-accept lo", lo, ml);

    // Flush during busy cycle 2 is ignored; result commits on schedule.
    issue(OP_MULT, 32'd3, 32'd4, 1'b0, 1'b1, "flush-busy");
    wait_idle(2, 1, n);
    check("flush-busy cycles", n, MULC);
    check("flush-busy hi", hi, 32'h0);
    check("flush-busy lo", lo, 32'd12);

    // Stray MTHI during DIV busy is ignored.
    issue(OP_DIV, 32'd17, 32'd5, 1'b0, 1'b1, "stray");
    wait_idle(3, 2, n);
    check("stray cycles", n, DIVC);
    check("stray hi", hi, 32'd2);
    check("stray lo", lo, 32'd3);

    // Reset on DIV busy cycle 3 discards the op.
    issue(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b1, "rst-div");
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check("rst-div busy", {31'h0, busy}, 32'h0);
    check("rst-div hi", hi, 32'h0);
    check("rst-div lo", lo, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst-div after release busy", {31'h0, busy}, 32'h0);
    issue(OP_MULT, 32'd6, 32'd7, 1'b0, 1'b1, "mult42");
    wait_idle(0, 0, n);
    check("mult42 cycles", n, MULC);
    check("mult42 hi", hi, 32'h0);
    check("mult42 lo", lo, 32'd42);
    mh = 32'h0; ml = 32'd42;

    // Randomized ops against the reference model.
    for (int k = 0; k < 40; k++) begin
      op_t         o;
      logic [31:0] a, b, eh, el;
      int          ec;
      o = op_t'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      eh = mh; el = ml;
      ref_op(o, a, b, eh, el);
      ec = (o == OP_MULT || o == OP_MULTU) ? MULC :
           (o == OP_DIV  || o == OP_DIVU)  ? DIVC : 0;
      issue(o, a, b, 1'b0, ec != 0, $sformatf("rnd%0d", k));
      wait_idle(0, 0, n);
      check($sformatf("rnd%0d op%0d cycles", k, o), n, ec);
      check($sformatf("rnd%0d op%0d a=%h b=%h hi", k, o, a, b), hi, eh);
      check($sformatf("rnd%0d op%0d a=%h b=%h lo", k, o, a, b), lo, el);
      mh = eh; ml = el;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
